// File: rtl/id_queue_stage_if.sv
// Fetch-side and execute-side handshake bundle for id_queue_stage.
// The slave modport is the decode stage's view; master is the driver/consumer view.
interface id_queue_stage_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ADDR_W-1:0] in_pc_i;
    logic [31:0]       in_inst_i;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [ADDR_W-1:0] out_pc_o;
    logic [6:0]        out_opcode_o;
    logic [2:0]        out_funct3_o;
    logic [6:0]        out_funct7_o;
    logic [4:0]        out_rd_o;
    logic [4:0]        out_rs1_o;
    logic [4:0]        out_rs2_o;
    logic              out_rd_we_o;
    logic              out_rs1_re_o;
    logic              out_rs2_re_o;
    logic [XLEN-1:0]   out_imm_o;
    logic [11:0]       out_csr_o;
    logic              out_illegal_o;

    modport slave (
        input  in_valid_i, in_pc_i, in_inst_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_funct3_o,
               out_funct7_o, out_rd_o, out_rs1_o, out_rs2_o, out_rd_we_o,
               out_rs1_re_o, out_rs2_re_o, out_imm_o, out_csr_o, out_illegal_o
    );

    modport master (
        output in_valid_i, in_pc_i, in_inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_funct3_o,
               out_funct7_o, out_rd_o, out_rs1_o, out_rs2_o, out_rd_we_o,
               out_rs1_re_o, out_rs2_re_o, out_imm_o, out_csr_o, out_illegal_o
    );
endinterface

// File: rtl/id_queue_stage.sv
// RV32I decode stage: DEPTH-entry instruction FIFO, head decoder, registered output slot.
// Define ID_QUEUE_ZICSR_EN to decode SYSTEM/CSR instructions; otherwise opcode 0x73 is illegal.
module id_queue_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    id_queue_stage_if.slave        bus,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
`ifdef ID_QUEUE_ZICSR_EN
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              rd_we;
        logic              rs1_re;
        logic              rs2_re;
        logic [XLEN-1:0]   imm;
        logic [11:0]       csr;
        logic              illegal;
    } dec_t;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q;
    dec_t             dec_q, dec_d;

    logic push, load, out_valid;

    assign out_valid = (state_q == S_FULL);
    assign push      = bus.in_valid_i & bus.in_ready_o;
    assign load      = (count_q != '0) & (~out_valid | bus.out_ready_i);
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(load);

    // Head of queue and its fields
    logic [ADDR_W-1:0] head_pc;
    logic [31:0]       ins;
    logic [6:0]        op, f7;
    logic [2:0]        f3;
    logic [4:0]        rd, rs1, rs2;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign head_pc = pc_mem[rd_ptr_q];
    assign ins     = inst_mem[rd_ptr_q];
    assign op      = ins[6:0];
    assign f3      = ins[14:12];
    assign f7      = ins[31:25];
    assign rd      = ins[11:7];
    assign rs1     = ins[19:15];
    assign rs2     = ins[24:20];

    assign imm_i  = {{(XLEN-12){ins[31]}}, ins[31:20]};
    assign imm_s  = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
    assign imm_j  = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_sh = {{(XLEN-5){1'b0}}, ins[24:20]};

    logic ill;

    always_comb begin
        dec_d        = '0;
        ill          = 1'b0;
        dec_d.pc     = head_pc;
        dec_d.opcode = op;
        case (op)
            OPC_OPIMM: begin
                dec_d.funct3 = f3;
                dec_d.rd     = rd;
                dec_d.rs1    = rs1;
                dec_d.rd_we  = 1'b1;
                dec_d.rs1_re = 1'b1;
                dec_d.imm    = imm_i;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    dec_d.imm    = imm_sh;
                    dec_d.funct7 = f7;
                    // Only SRAI may carry funct7=0x20
                    ill = (f7 != 7'h00) && !(f3 == 3'd5 && f7 == 7'h20);
                end
            end
            OPC_LOAD: begin
                dec_d.funct3 = f3;
                dec_d.rd     = rd;
                dec_d.rs1    = rs1;
                dec_d.rd_we  = 1'b1;
                dec_d.rs1_re = 1'b1;
                dec_d.imm    = imm_i;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                dec_d.funct3 = f3;
                dec_d.rs1    = rs1;
                dec_d.rs2    = rs2;
                dec_d.rs1_re = 1'b1;
                dec_d.rs2_re = 1'b1;
                dec_d.imm    = imm_s;
                ill = (f3 > 3'd2);
            end
            OPC_OP: begin
                dec_d.funct3 = f3;
                dec_d.funct7 = f7;
                dec_d.rd     = rd;
                dec_d.rs1    = rs1;
                dec_d.rs2    = rs2;
                dec_d.rd_we  = 1'b1;
                dec_d.rs1_re = 1'b1;
                dec_d.rs2_re = 1'b1;
                ill = !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01);
            end
            OPC_BRANCH: begin
                dec_d.funct3 = f3;
                dec_d.rs1    = rs1;
                dec_d.rs2    = rs2;
                dec_d.rs1_re = 1'b1;
                dec_d.rs2_re = 1'b1;
                dec_d.imm    = imm_b;
                ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_JAL: begin
                dec_d.rd    = rd;
                dec_d.rd_we = 1'b1;
                dec_d.imm   = imm_j;
            end
            OPC_JALR: begin
                dec_d.funct3 = f3;
                dec_d.rd     = rd;
                dec_d.rs1    = rs1;
                dec_d.rd_we  = 1'b1;
                dec_d.rs1_re = 1'b1;
                dec_d.imm    = imm_i;
                ill = (f3 != 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_d.rd    = rd;
                dec_d.rd_we = 1'b1;
                dec_d.imm   = imm_u;
            end
            OPC_FENCE: begin
                dec_d.funct3 = f3;
            end
`ifdef ID_QUEUE_ZICSR_EN
            OPC_SYSTEM: begin
                dec_d.funct3 = f3;
                dec_d.csr    = ins[31:20];
                dec_d.rd     = rd;
                dec_d.rd_we  = 1'b1;
                if (f3 == 3'd0 || f3 == 3'd4) begin
                    ill = 1'b1;
                end else if (f3[2]) begin
                    dec_d.imm = {{(XLEN-5){1'b0}}, ins[19:15]};
                end else begin
                    dec_d.rs1    = rs1;
                    dec_d.rs1_re = 1'b1;
                end
            end
`endif
            default: ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) ill = 1'b1;
        // Illegal words still flow in order, carrying only pc/opcode and the flag
        if (ill) begin
            dec_d         = '0;
            dec_d.pc      = head_pc;
            dec_d.opcode  = op;
            dec_d.illegal = 1'b1;
        end
        if (dec_d.rd == 5'd0) dec_d.rd_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && push) begin
            pc_mem[wr_ptr_q]   <= bus.in_pc_i;
            inst_mem[wr_ptr_q] <= bus.in_inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_EMPTY;
            dec_q    <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            case (state_q)
                S_EMPTY: if (load) begin
                    dec_q    <= dec_d;
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    state_q  <= S_FULL;
                end
                S_FULL: if (load) begin
                    dec_q    <= dec_d;
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end else if (bus.out_ready_i) begin
                    dec_q   <= '0;
                    state_q <= S_EMPTY;
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign bus.in_ready_o    = (count_q != CNT_W'(DEPTH));
    assign level_o           = count_q;
    assign bus.out_valid_o   = out_valid;
    assign bus.out_pc_o      = dec_q.pc;
    assign bus.out_opcode_o  = dec_q.opcode;
    assign bus.out_funct3_o  = dec_q.funct3;
    assign bus.out_funct7_o  = dec_q.funct7;
    assign bus.out_rd_o      = dec_q.rd;
    assign bus.out_rs1_o     = dec_q.rs1;
    assign bus.out_rs2_o     = dec_q.rs2;
    assign bus.out_rd_we_o   = dec_q.rd_we;
    assign bus.out_rs1_re_o  = dec_q.rs1_re;
    assign bus.out_rs2_re_o  = dec_q.rs2_re;
    assign bus.out_imm_o     = dec_q.imm;
    assign bus.out_csr_o     = dec_q.csr;
    assign bus.out_illegal_o = dec_q.illegal;
endmodule

// File: tb/tb_id_queue_stage.sv
// Directed bench for id_queue_stage: latency, backpressure, streaming, flush, illegal and CSR decode.
module tb_id_queue_stage;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_i;
    logic [2:0] level_o;

    int n_cmp = 0;
    int n_err = 0;

    id_queue_stage_if #(.ADDR_W(32), .XLEN(32)) bus ();

    id_queue_stage #(.ADDR_W(32), .XLEN(32), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus),
        .level_o (level_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid_i = v;
        bus.in_pc_i    = pc;
        bus.in_inst_i  = inst;
    endtask

    // Push one word with out_ready=1; on return the decoded word sits in the slot
    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        drive(1'b1, pc, inst);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    logic [31:0] fpc  [6];
    logic [31:0] fins [6];

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_ready", bus.in_ready_o, 1);
        chk("rst_pc", bus.out_pc_o, 0);
        chk("rst_imm", bus.out_imm_o, 0);

        // Single ADDI x1,x0,-1: visible after the second edge
        drive(1'b1, 32'h100, 32'hFFF00093);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("lat_level1", level_o, 1);
        chk("lat_valid_early", bus.out_valid_o, 0);
        tick();
        chk("addi_valid", bus.out_valid_o, 1);
        chk("addi_pc", bus.out_pc_o, 32'h100);
        chk("addi_rd", bus.out_rd_o, 1);
        chk("addi_rs1", bus.out_rs1_o, 0);
        chk("addi_imm", bus.out_imm_o, 32'hFFFFFFFF);
        chk("addi_rdwe", bus.out_rd_we_o, 1);
        chk("addi_ill", bus.out_illegal_o, 0);
        chk("addi_level0", level_o, 0);
        bus.out_ready_i = 1'b1;
        tick();
        chk("addi_drained", bus.out_valid_o, 0);
        chk("drained_pc", bus.out_pc_o, 0);

        // Backpressure: ADD, SW, BEQ, LUI, JAL held while out_ready=0
        fpc[0] = 32'h200; fins[0] = 32'h002081B3;
        fpc[1] = 32'h204; fins[1] = 32'h0020A223;
        fpc[2] = 32'h208; fins[2] = 32'h00208463;
        fpc[3] = 32'h20C; fins[3] = 32'h123452B7;
        fpc[4] = 32'h210; fins[4] = 32'h010000EF;
        fpc[5] = 32'h214; fins[5] = 32'h00700393;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, fpc[i], fins[i]);
            tick();
        end
        chk("full_ready", bus.in_ready_o, 0);
        chk("full_level", level_o, 4);
        drive(1'b1, 32'h999, 32'h00000013);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("full_nopush", level_o, 4);
        chk("hold_pc", bus.out_pc_o, 32'h200);
        chk("hold_rd", bus.out_rd_o, 3);
        chk("hold_rs2", bus.out_rs2_o, 2);
        chk("hold_rs2re", bus.out_rs2_re_o, 1);
        chk("hold_f7", bus.out_funct7_o, 0);

        bus.out_ready_i = 1'b1;
        tick();
        chk("sw_pc", bus.out_pc_o, 32'h204);
        chk("sw_imm", bus.out_imm_o, 4);
        chk("sw_rdwe", bus.out_rd_we_o, 0);
        chk("sw_level", level_o, 3);
        // Push and load together at count==DEPTH-1
        drive(1'b1, fpc[5], fins[5]);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("beq_pc", bus.out_pc_o, 32'h208);
        chk("beq_imm", bus.out_imm_o, 8);
        chk("pushpop_level", level_o, 3);
        tick();
        chk("lui_pc", bus.out_pc_o, 32'h20C);
        chk("lui_imm", bus.out_imm_o, 32'h12345000);
        chk("lui_f3", bus.out_funct3_o, 0);
        chk("lui_rd", bus.out_rd_o, 5);
        tick();
        chk("jal_pc", bus.out_pc_o, 32'h210);
        chk("jal_imm", bus.out_imm_o, 16);
        chk("jal_rd", bus.out_rd_o, 1);
        tick();
        chk("addi7_pc", bus.out_pc_o, 32'h214);
        chk("addi7_imm", bus.out_imm_o, 7);
        chk("q_level0", level_o, 0);
        tick();
        chk("q_empty", bus.out_valid_o, 0);

        // Back-to-back stream: one push per cycle, level stays at 1
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), (32'(i) << 20) | 32'h00000093);
            tick();
            if (i > 0) begin
                chk("bb_valid", bus.out_valid_o, 1);
                chk("bb_level", level_o, 1);
                chk("bb_imm", bus.out_imm_o, 64'(i - 1));
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("bb_last", bus.out_imm_o, 5);
        chk("bb_lvl0", level_o, 0);
        tick();
        chk("bb_empty", bus.out_valid_o, 0);

        // Flush with 3 queued entries and a push in the same cycle
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 32'h00000013);
            tick();
        end
        chk("pre_flush_level", level_o, 3);
        flush_i = 1'b1;
        drive(1'b1, 32'hBAD, 32'h00100093);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready_i = 1'b1;
        chk("flush_valid", bus.out_valid_o, 0);
        chk("flush_level", level_o, 0);
        chk("flush_ready", bus.in_ready_o, 1);
        tick();
        chk("flush_nopush", bus.out_valid_o, 0);
        chk("flush_lvl", level_o, 0);
        send(32'h400, 32'h00200113);
        chk("postflush_pc", bus.out_pc_o, 32'h400);
        chk("postflush_rd", bus.out_rd_o, 2);

        // Illegal and boundary encodings
        send(32'h600, 32'h00000000);
        chk("zero_ill", bus.out_illegal_o, 1);
        chk("zero_flags", {bus.out_rd_we_o, bus.out_rs1_re_o, bus.out_rs2_re_o}, 0);
        chk("zero_imm", bus.out_imm_o, 0);
        send(32'h604, 32'h0000F067);
        chk("jalr_f3_ill", bus.out_illegal_o, 1);
        chk("jalr_ill_rd", bus.out_rd_o, 0);
        send(32'h608, 32'h40005013);
        chk("srai_ill", bus.out_illegal_o, 0);
        chk("srai_f7", bus.out_funct7_o, 7'h20);
        send(32'h60C, 32'h40001013);
        chk("slli_f7_ill", bus.out_illegal_o, 1);
        send(32'h610, 32'h0020B463);
        chk("bra_f3_ill", bus.out_illegal_o, 1);
        send(32'h614, 32'h02208133);
        chk("mul_f7_legal", bus.out_illegal_o, 0);
        chk("mul_f7", bus.out_funct7_o, 7'h01);

        // CSRRWI x2,mstatus,5
        send(32'h700, 32'h3002D173);
        chk("csr_pc", bus.out_pc_o, 32'h700);
`ifdef ID_QUEUE_ZICSR_EN
        chk("csr_ill", bus.out_illegal_o, 0);
        chk("csr_addr", bus.out_csr_o, 12'h300);
        chk("csr_imm", bus.out_imm_o, 5);
        chk("csr_rd", bus.out_rd_o, 2);
        chk("csr_rs1re", bus.out_rs1_re_o, 0);
        chk("csr_rdwe", bus.out_rd_we_o, 1);
`else
        chk("csr_ill", bus.out_illegal_o, 1);
        chk("csr_addr", bus.out_csr_o, 0);
        chk("csr_imm", bus.out_imm_o, 0);
`endif
        tick();
        chk("end_empty", bus.out_valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
